tawas_rcn_master: RTL and testbench

RCN ring initiator for the Tawas core. Accepts per-thread load/store requests from the pipeline memory stage and queues them for insertion onto the ring. It consumes responses addressed to this node and returns load data to the register file through its `rcn_load_*` writeback port. It also keeps a per-thread busy vector so the pipeline stalls a thread while its bus access is outstanding.

---
 rtl/tawas_rcn_master.sv | 208 ++++++++++++++++++++
 tb/tb_tawas_rcn_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tawas_rcn_master.sv
// Tawas RCN ring initiator: queues per-thread loads/stores and inserts them into free ring slots.
// It retires matching responses to the register file or to a store acknowledge.

// Generic synchronous FIFO; the head entry is readable combinationally.
// Zero-latency head, push visible next cycle; the caller must not push when full.
module tawas_rcn_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full     = cnt_q[AW];
  assign empty    = (cnt_q == '0);
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_vld & ~full;
    do_pop   = pop_vld & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

// Ring initiator top: pending table per thread, issue FIFO, slot consume/pass/insert.
// Ring egress registered (accept to rcn_out >= 2 cycles); writeback 1 cycle after response.
// req_ready drops when the FIFO is full; busy threads get req_err instead of stalling.
module tawas_rcn_master #(
  parameter logic MASTER_ID  = 1'b0,
  parameter int   FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  output logic        req_ready,
  input  logic [4:0]  req_thread,
  input  logic        req_wr,
  input  logic [2:0]  req_reg,
  input  logic [3:0]  req_mask,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] thread_busy,
  input  logic [68:0] rcn_in,
  output logic [68:0] rcn_out,
  output logic        rcn_load_en,
  output logic [4:0]  rcn_load_thread,
  output logic [2:0]  rcn_load_reg,
  output logic [31:0] rcn_load_data,
  output logic        store_done,
  output logic [4:0]  store_done_thread,
  output logic        req_err,
  output logic        rsp_err
);
  logic [31:0]      pend_vld_q, pend_vld_d;
  logic [31:0]      pend_wr_q, pend_wr_d;
  logic [31:0][2:0] pend_reg_q, pend_reg_d;
  logic [31:0][1:0] pend_seq_q, pend_seq_d;

  logic [68:0] rcn_out_q, rcn_out_d;
  logic        load_en_q, load_en_d;
  logic [4:0]  load_thread_q, load_thread_d;
  logic [2:0]  load_reg_q, load_reg_d;
  logic [31:0] load_data_q, load_data_d;
  logic        store_done_q, store_done_d;
  logic [4:0]  store_thread_q, store_thread_d;
  logic        req_err_q, req_err_d;
  logic        rsp_err_q, rsp_err_d;

  logic        rsp_vld, rsp_hit, busy_hit, accept, pass, pop;
  logic [4:0]  rsp_thread;
  logic [1:0]  seq_new;
  logic [68:0] push_dat, head_dat;
  logic        fifo_full, fifo_empty;
  logic        addr_unused;

  assign addr_unused = ^req_addr[1:0];
  assign req_ready   = ~fifo_full;
  assign thread_busy = pend_vld_q;

  always_comb begin
    rsp_vld    = rcn_in[68] & ~rcn_in[67] & (rcn_in[65] == MASTER_ID);
    rsp_thread = rcn_in[64:60];
    rsp_hit    = rsp_vld & pend_vld_q[rsp_thread] & (pend_seq_q[rsp_thread] == rcn_in[59:58]);
    // Uses the pre-completion busy bit, so a same-cycle retire still rejects the new request.
    busy_hit   = pend_vld_q[req_thread];
    accept     = req_en & req_ready & ~busy_hit;
    seq_new    = pend_seq_q[req_thread] + 2'd1;
    push_dat   = {1'b1, 1'b1, req_wr, MASTER_ID, req_thread, seq_new, req_mask,
                  req_addr[23:2], req_wr ? req_wdata : 32'h0};
    pass       = rcn_in[68] & ~rsp_vld;
    pop        = ~pass & ~fifo_empty;
  end

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_wr_d  = pend_wr_q;
    pend_reg_d = pend_reg_q;
    pend_seq_d = pend_seq_q;
    if (rsp_hit) pend_vld_d[rsp_thread] = 1'b0;
    if (accept) begin
      pend_vld_d[req_thread] = 1'b1;
      pend_wr_d[req_thread]  = req_wr;
      pend_reg_d[req_thread] = req_reg;
      pend_seq_d[req_thread] = seq_new;
    end

    rcn_out_d      = pass ? rcn_in : (pop ? head_dat : 69'h0);
    load_en_d      = rsp_hit & ~pend_wr_q[rsp_thread];
    load_thread_d  = load_en_d ? rsp_thread : 5'h0;
    load_reg_d     = load_en_d ? pend_reg_q[rsp_thread] : 3'h0;
    load_data_d    = load_en_d ? rcn_in[31:0] : 32'h0;
    store_done_d   = rsp_hit & pend_wr_q[rsp_thread];
    store_thread_d = store_done_d ? rsp_thread : 5'h0;
    req_err_d      = req_en & req_ready & busy_hit;
    rsp_err_d      = rsp_vld & ~rsp_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_q     <= '0;
      pend_wr_q      <= '0;
      pend_reg_q     <= '0;
      pend_seq_q     <= '0;
      rcn_out_q      <= '0;
      load_en_q      <= 1'b0;
      load_thread_q  <= '0;
      load_reg_q     <= '0;
      load_data_q    <= '0;
      store_done_q   <= 1'b0;
      store_thread_q <= '0;
      req_err_q      <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      pend_vld_q     <= pend_vld_d;
      pend_wr_q      <= pend_wr_d;
      pend_reg_q     <= pend_reg_d;
      pend_seq_q     <= pend_seq_d;
      rcn_out_q      <= rcn_out_d;
      load_en_q      <= load_en_d;
      load_thread_q  <= load_thread_d;
      load_reg_q     <= load_reg_d;
      load_data_q    <= load_data_d;
      store_done_q   <= store_done_d;
      store_thread_q <= store_thread_d;
      req_err_q      <= req_err_d;
      rsp_err_q      <= rsp_err_d;
    end
  end

  tawas_rcn_fifo #(
    .WIDTH (69),
    .DEPTH (FIFO_DEPTH)
  ) u_issue_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (accept),
    .push_dat (push_dat),
    .pop_vld  (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rcn_out           = rcn_out_q;
  assign rcn_load_en       = load_en_q;
  assign rcn_load_thread   = load_thread_q;
  assign rcn_load_reg      = load_reg_q;
  assign rcn_load_data     = load_data_q;
  assign store_done        = store_done_q;
  assign store_done_thread = store_thread_q;
  assign req_err           = req_err_q;
  assign rsp_err           = rsp_err_q;
endmodule

// File: tb/tb_tawas_rcn_master.sv
// Scoreboard bench for tawas_rcn_master: ring egress, writeback and error pulses.
module tb_tawas_rcn_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_en = 1'b0;
  logic        req_ready;
  logic [4:0]  req_thread = '0;
  logic        req_wr = 1'b0;
  logic [2:0]  req_reg = '0;
  logic [3:0]  req_mask = '0;
  logic [23:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] thread_busy;
  logic [68:0] rcn_in = '0;
  logic [68:0] rcn_out;
  logic        rcn_load_en;
  logic [4:0]  rcn_load_thread;
  logic [2:0]  rcn_load_reg;
  logic [31:0] rcn_load_data;
  logic        store_done;
  logic [4:0]  store_done_thread;
  logic        req_err;
  logic        rsp_err;

  always #5 clk = ~clk;

  tawas_rcn_master #(.MASTER_ID(1'b0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_ready(req_ready),
    .req_thread(req_thread), .req_wr(req_wr), .req_reg(req_reg), .req_mask(req_mask),
    .req_addr(req_addr), .req_wdata(req_wdata), .thread_busy(thread_busy),
    .rcn_in(rcn_in), .rcn_out(rcn_out), .rcn_load_en(rcn_load_en),
    .rcn_load_thread(rcn_load_thread), .rcn_load_reg(rcn_load_reg),
    .rcn_load_data(rcn_load_data), .store_done(store_done),
    .store_done_thread(store_done_thread), .req_err(req_err), .rsp_err(rsp_err)
  );

  int n_vec = 0;
  int n_bad = 0;
  int exp_req_err = 0, obs_req_err = 0;
  int exp_rsp_err = 0, obs_rsp_err = 0;

  logic [68:0] pass_q [$];
  logic [68:0] issue_q [$];
  logic [39:0] load_q [$];
  logic [4:0]  store_q [$];

  logic [31:0] model_busy = '0;
  logic [31:0] model_wr = '0;
  logic [2:0]  model_reg [32];
  logic [1:0]  model_seq [32];

  task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [68:0] mk_req(input logic [4:0] t, input logic wr, input logic [3:0] mask,
                                         input logic [23:0] addr, input logic [31:0] wd,
                                         input logic [1:0] seq);
    logic [68:0] p;
    p = '0;
    p[68] = 1'b1;
    p[67] = 1'b1;
    p[66] = wr;
    p[65] = 1'b0;
    p[64:60] = t;
    p[59:58] = seq;
    p[57:54] = mask;
    p[53:32] = addr[23:2];
    p[31:0] = wr ? wd : 32'h0;
    return p;
  endfunction

  function automatic logic [68:0] foreign_pkt();
    logic [95:0] r;
    logic [68:0] p;
    r = {$urandom, $urandom, $urandom};
    p = r[68:0];
    p[68] = 1'b1;
    p[65] = 1'b1;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rcn_out[68]) begin
        if (rcn_out[65]) begin
          if (pass_q.size() == 0) chk("pass_unexpected", rcn_out, 69'h0);
          else chk("pass", rcn_out, pass_q.pop_front());
        end else if (rcn_out[67]) begin
          if (issue_q.size() == 0) chk("issue_unexpected", rcn_out, 69'h0);
          else chk("issue", rcn_out, issue_q.pop_front());
        end else begin
          chk("own_rsp_leak", rcn_out, 69'h0);
        end
      end
      if (rcn_load_en) begin
        if (load_q.size() == 0) chk("load_unexpected", 69'({rcn_load_thread, rcn_load_reg, rcn_load_data}), 69'h0);
        else chk("load_wb", 69'({rcn_load_thread, rcn_load_reg, rcn_load_data}), 69'(load_q.pop_front()));
      end
      if (store_done) begin
        if (store_q.size() == 0) chk("store_unexpected", 69'(store_done_thread), 69'h0);
        else chk("store_ack", 69'(store_done_thread), 69'(store_q.pop_front()));
      end
      if (req_err) obs_req_err++;
      if (rsp_err) obs_rsp_err++;
    end
  end

  task automatic do_req(input logic [4:0] t, input logic wr, input logic [2:0] rg, input logic [3:0] mask,
                        input logic [23:0] addr, input logic [31:0] wd, input logic exp_ready);
    req_en = 1'b1; req_thread = t; req_wr = wr; req_reg = rg;
    req_mask = mask; req_addr = addr; req_wdata = wd;
    chk("req_ready", 69'(req_ready), 69'(exp_ready));
    if (exp_ready) begin
      if (model_busy[t]) begin
        exp_req_err++;
      end else begin
        model_seq[t] = model_seq[t] + 2'd1;
        model_busy[t] = 1'b1;
        model_wr[t] = wr;
        model_reg[t] = rg;
        issue_q.push_back(mk_req(t, wr, mask, addr, wd, model_seq[t]));
      end
    end
    step();
    req_en = 1'b0;
    chk("busy_after_req", 69'(thread_busy), 69'(model_busy));
  endtask

  task automatic send_rsp(input logic [4:0] t, input logic [1:0] seq, input logic [31:0] data);
    logic hit;
    rcn_in = {1'b1, 1'b0, 1'b0, 1'b0, t, seq, 4'h0, 22'h0, data};
    hit = model_busy[t] && (model_seq[t] == seq);
    if (hit) begin
      model_busy[t] = 1'b0;
      if (model_wr[t]) store_q.push_back(t);
      else load_q.push_back({t, model_reg[t], data});
    end else begin
      exp_rsp_err++;
    end
    step();
    rcn_in = '0;
    chk("rsp_busy", 69'(thread_busy), 69'(model_busy));
    chk("rsp_load_en", 69'(rcn_load_en), 69'(hit && !model_wr[t]));
    chk("rsp_store_done", 69'(store_done), 69'(hit && model_wr[t]));
    chk("rsp_err_pulse", 69'(rsp_err), 69'(!hit));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      model_seq[i] = 2'd0;
      model_reg[i] = 3'd0;
    end
    repeat (3) step();
    chk("rst_rcn_out", rcn_out, 69'h0);
    chk("rst_ready", 69'(req_ready), 69'h1);
    chk("rst_busy", 69'(thread_busy), 69'h0);
    chk("rst_pulses", 69'({rcn_load_en, store_done, req_err, rsp_err}), 69'h0);
    chk("rst_load", 69'({rcn_load_thread, rcn_load_reg, rcn_load_data}), 69'h0);
    rst = 1'b0;
    step();

    // Idle-ring load on thread 3.
    do_req(5'd3, 1'b0, 3'd5, 4'hF, 24'h000100, 32'h0, 1'b1);
    chk("load_out_e1", rcn_out, 69'h0);
    step();
    chk("load_out_e2", rcn_out, {1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 2'd1, 4'hF, 22'h40, 32'h0});
    step();
    send_rsp(5'd3, 2'd1, 32'hDEADBEEF);
    chk("load_thread_reg", 69'({rcn_load_thread, rcn_load_reg}), 69'({5'd3, 3'd5}));
    chk("load_data", 69'(rcn_load_data), 69'h0DEADBEEF);
    step();
    chk("load_en_pulse", 69'(rcn_load_en), 69'h0);

    // Store on thread 7.
    do_req(5'd7, 1'b1, 3'd0, 4'b0011, 24'h000200, 32'h12345678, 1'b1);
    repeat (2) step();
    send_rsp(5'd7, model_seq[7], 32'h0);
    chk("store_thread", 69'(store_done_thread), 69'd7);

    // Busy thread rejection, then a completion racing a new request.
    do_req(5'd3, 1'b0, 3'd2, 4'hF, 24'h000300, 32'h0, 1'b1);
    repeat (2) step();
    do_req(5'd3, 1'b0, 3'd6, 4'hF, 24'h000400, 32'h0, 1'b1);
    chk("req_err_pulse", 69'(req_err), 69'h1);
    step();
    chk("req_err_clear", 69'(req_err), 69'h0);
    rcn_in = {1'b1, 1'b0, 1'b0, 1'b0, 5'd3, model_seq[3], 4'h0, 22'h0, 32'hCAFE0003};
    req_en = 1'b1; req_thread = 5'd3; req_wr = 1'b0; req_reg = 3'd1;
    model_busy[3] = 1'b0;
    load_q.push_back({5'd3, model_reg[3], 32'hCAFE0003});
    exp_req_err++;
    step();
    rcn_in = '0; req_en = 1'b0;
    chk("race_req_err", 69'(req_err), 69'h1);
    chk("race_load_en", 69'(rcn_load_en), 69'h1);
    chk("race_busy", 69'(thread_busy), 69'(model_busy));
    repeat (3) step();

    // Saturated ring: 5 requests, FIFO holds 4, nothing inserted until a free slot.
    for (int c = 0; c < 10; c++) begin
      rcn_in = foreign_pkt();
      pass_q.push_back(rcn_in);
      if (c < 5) do_req(5'(c), 1'b0, 3'(c), 4'hF, 24'h001000 + 24'(c * 4), 32'h0, c < 4);
      else step();
      chk("sat_pass_only", 69'(rcn_out[65]), 69'h1);
    end
    rcn_in = '0;
    step();
    chk("first_insert", rcn_out, mk_req(5'd0, 1'b0, 4'hF, 24'h001000, 32'h0, 2'd1));
    repeat (5) step();
    for (int t = 0; t < 4; t++) send_rsp(5'(t), model_seq[t], 32'h5A5A0000 + 32'(t));

    // Idle-thread and wrong-seq responses.
    send_rsp(5'd5, 2'd0, 32'h11111111);
    chk("idle_rsp_consumed", rcn_out, 69'h0);
    do_req(5'd6, 1'b0, 3'd3, 4'hF, 24'h002000, 32'h0, 1'b1);
    repeat (2) step();
    send_rsp(5'd6, model_seq[6] + 2'd1, 32'h22222222);
    chk("badseq_consumed", rcn_out, 69'h0);
    send_rsp(5'd6, model_seq[6], 32'h33333333);
    step();

    // Reset with three loads in flight.
    for (int t = 8; t < 11; t++) do_req(5'(t), 1'b0, 3'(t - 8), 4'hF, 24'h003000 + 24'(t * 4), 32'h0, 1'b1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_busy = '0;
    for (int i = 0; i < 32; i++) model_seq[i] = 2'd0;
    chk("midrst_busy", 69'(thread_busy), 69'h0);
    chk("midrst_ready", 69'(req_ready), 69'h1);
    for (int t = 8; t < 11; t++) send_rsp(5'(t), 2'd1, 32'h44440000 + 32'(t));
    repeat (2) step();

    chk("pass_q_left", 69'(pass_q.size()), 69'h0);
    chk("issue_q_left", 69'(issue_q.size()), 69'h0);
    chk("load_q_left", 69'(load_q.size()), 69'h0);
    chk("store_q_left", 69'(store_q.size()), 69'h0);
    chk("req_err_count", 69'(obs_req_err), 69'(exp_req_err));
    chk("rsp_err_count", 69'(obs_rsp_err), 69'(exp_rsp_err));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
